// File: rtl/xvga_timing_gen.sv
// XVGA (1024x768@60) raster timing generator and output stage: counters, sync/blank
// decode, frame tracking, and the latency-matched sync/blank delay with RGB blanking.
module xvga_timing_gen #(
  parameter int unsigned H_ACTIVE      = 1024,
  parameter int unsigned H_FP          = 24,
  parameter int unsigned H_SYNC        = 136,
  parameter int unsigned H_BP          = 160,
  parameter int unsigned V_ACTIVE      = 768,
  parameter int unsigned V_FP          = 3,
  parameter int unsigned V_SYNC        = 6,
  parameter int unsigned V_BP          = 29,
  parameter int unsigned PIXEL_LATENCY = 2
) (
  input  logic        vclock,
  input  logic        reset_n,
  output logic [10:0] hcount,
  output logic [9:0]  vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic        frame_start,
  output logic [15:0] frame_count,
  input  logic [23:0] pixel_in,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_blank,
  output logic [23:0] vga_rgb
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] hcount_q, hcount_d;
  logic [9:0]  vcount_q, vcount_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        blank_q, blank_d;
  logic        frame_start_q, frame_start_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        h_last, v_last;

  // Decode works on the next counter values so the registered flags line up with the counters.
  always_comb begin
    h_last        = (hcount_q == H_LAST);
    v_last        = (vcount_q == V_LAST);
    hcount_d      = h_last ? '0 : hcount_q + 11'd1;
    vcount_d      = vcount_q;
    if (h_last) begin
      vcount_d = v_last ? '0 : vcount_q + 10'd1;
    end
    hsync_d       = !((hcount_d >= HS_START) && (hcount_d < HS_END));
    vsync_d       = !((vcount_d >= VS_START) && (vcount_d < VS_END));
    blank_d       = (hcount_d >= H_VIS) || (vcount_d >= V_VIS);
    frame_start_d = h_last && v_last;
    frame_count_d = frame_count_q;
    if (h_last && v_last) begin
      frame_count_d = frame_count_q + 16'd1;
    end
  end

  always_ff @(posedge vclock) begin
    if (!reset_n) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      blank_q       <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blank_q       <= blank_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank       = blank_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

  generate
    if (PIXEL_LATENCY == 0) begin : g_nodelay
      assign vga_hsync = hsync_q;
      assign vga_vsync = vsync_q;
      assign vga_blank = blank_q;
    end else begin : g_delay
      localparam int unsigned DW = 3 * PIXEL_LATENCY;
      // Packed shift register of {hsync, vsync, blank}; newest entry in the low 3 bits.
      logic [DW-1:0] dly_q, dly_d;

      always_comb begin
        dly_d = (dly_q << 3) | DW'({hsync_q, vsync_q, blank_q});
      end

      always_ff @(posedge vclock) begin
        if (!reset_n) begin
          dly_q <= '1;
        end else begin
          dly_q <= dly_d;
        end
      end

      assign vga_hsync = dly_q[DW-1];
      assign vga_vsync = dly_q[DW-2];
      assign vga_blank = dly_q[DW-3];
    end
  endgenerate

  always_comb begin
    vga_rgb = vga_blank ? '0 : pixel_in;
  end

endmodule
